// File: rtl/pe_pair_picker.sv
// pe_pair_picker: turns raw 32-bit random words into distinct, in-range PE index
// pairs (a, b) that the annealing placer proposes to swap. Rejected draws are resampled.
// Latency: 5 cycles from enable_i seen in IDLE to pair_valid_o when there are no rejects.
// Backpressure: the pair is held stable in OUT until pair_ready_i; no draws are made meanwhile.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   enable_i              - allows a new proposal to start (checked in IDLE and on OUT exit)
//   seed_load_i, seed_i   - seed request; passed straight to the random stage, aborts the FSM
//   rand_i                - random word, valid the cycle after next_rand_o
//   next_rand_o           - one-cycle request for a new random word
//   loadseed_o, seed_o    - seed-load strobe and value to the random stage
//   pair_valid_o/ready_i  - valid/ready handshake for the proposal pe_a_o/pe_b_o
//   reject_cnt_o          - saturating count of rejected draws since reset or seed load
//   busy_o                - high whenever the FSM is not IDLE
module pe_pair_picker #(
  parameter int N_PE  = 16,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             seed_load_i,
  input  logic [31:0]      seed_i,
  input  logic [31:0]      rand_i,
  output logic             next_rand_o,
  output logic             loadseed_o,
  output logic [31:0]      seed_o,
  output logic             pair_valid_o,
  input  logic             pair_ready_i,
  output logic [IDX_W-1:0] pe_a_o,
  output logic [IDX_W-1:0] pe_b_o,
  output logic [CNT_W-1:0] reject_cnt_o,
  output logic             busy_o
);

  // Reject parameter sets that cannot produce two distinct legal indices.
  generate
    if (N_PE < 2 || IDX_W < 1 || IDX_W > 31 || (1 << IDX_W) < N_PE) begin : g_bad_params
      $error("pe_pair_picker: illegal N_PE/IDX_W combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_A  = 3'd1,
    S_WAIT_A = 3'd2,
    S_REQ_B  = 3'd3,
    S_WAIT_B = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  // One extra bit so N_PE == 2^IDX_W still compares correctly.
  localparam logic [IDX_W:0] N_PE_W = (IDX_W+1)'(N_PE);

  state_t           state_q;
  logic             next_rand_q;
  logic             valid_q;
  logic             busy_q;
  logic [IDX_W-1:0] a_q;
  logic [IDX_W-1:0] b_q;
  logic [CNT_W-1:0] reject_cnt_q;
  logic [CNT_W-1:0] reject_cnt_d;

  logic [IDX_W-1:0] cand;
  logic             cand_in_range;
  logic             cand_ok_b;
  logic             unused_rand_hi;

  assign cand           = rand_i[IDX_W-1:0];
  assign unused_rand_hi = ^rand_i[31:IDX_W];
  assign cand_in_range  = ({1'b0, cand} < N_PE_W);
  assign cand_ok_b      = cand_in_range && (cand != a_q);

  // Saturating increment: holds at all-ones instead of wrapping.
  assign reject_cnt_d = (reject_cnt_q == {CNT_W{1'b1}}) ? reject_cnt_q
                                                        : reject_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      next_rand_q  <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      reject_cnt_q <= '0;
    end else if (seed_load_i) begin
      // Seed load wins over everything, including an OUT handshake this cycle:
      // the pending pair is dropped and the random stream restarts from IDLE.
      state_q      <= S_IDLE;
      next_rand_q  <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      reject_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_i) begin
            state_q     <= S_REQ_A;
            next_rand_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_REQ_A: begin
          state_q     <= S_WAIT_A;
          next_rand_q <= 1'b0;
        end
        S_WAIT_A: begin
          // Either outcome issues a new request next cycle.
          next_rand_q <= 1'b1;
          if (cand_in_range) begin
            a_q     <= cand;
            state_q <= S_REQ_B;
          end else begin
            reject_cnt_q <= reject_cnt_d;
            state_q      <= S_REQ_A;
          end
        end
        S_REQ_B: begin
          state_q     <= S_WAIT_B;
          next_rand_q <= 1'b0;
        end
        S_WAIT_B: begin
          if (cand_ok_b) begin
            b_q     <= cand;
            valid_q <= 1'b1;
            state_q <= S_OUT;
          end else begin
            // a_q is kept; only b is redrawn.
            reject_cnt_q <= reject_cnt_d;
            next_rand_q  <= 1'b1;
            state_q      <= S_REQ_B;
          end
        end
        S_OUT: begin
          if (pair_ready_i) begin
            valid_q <= 1'b0;
            if (enable_i) begin
              state_q     <= S_REQ_A;
              next_rand_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          next_rand_q <= 1'b0;
          valid_q     <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // The request is suppressed while a seed is being loaded into the random stage.
  assign next_rand_o  = next_rand_q & ~seed_load_i;
  assign loadseed_o   = seed_load_i;
  assign seed_o       = seed_i;
  assign pair_valid_o = valid_q;
  assign pe_a_o       = a_q;
  assign pe_b_o       = b_q;
  assign reject_cnt_o = reject_cnt_q;
  assign busy_o       = busy_q;

endmodule

// File: doc/pe_pair_picker.md
Name: pe_pair_picker

Overview:
- Draws raw 32-bit random words from the upstream random-number stage and turns them into swap proposals for the annealing placer.
- Each proposal is a pair of distinct, in-range PE indices (a, b).
- Out-of-range or duplicate draws are rejected by resampling.
- Owns the request (next_rand) and seed-load controls of the random stage; delivers pairs downstream over a valid/ready handshake.

Parameters:
N_PE, 16, number of placeable PEs; legal range 2..2^IDX_W.
IDX_W, 4, width of a PE index; must satisfy 2^IDX_W >= N_PE.
CNT_W, 16, width of the saturating reject counter.

Ports:
clk  in  1  clock, all state on rising edge.
reset  in  1  asynchronous, active-high reset.
enable_i  in  1  permits new proposals to start.
seed_load_i  in  1  request seed load of the random stage.
seed_i  in  32  seed value.
rand_i  in  32  random word from the random stage (its number output).
next_rand_o  out  1  one-cycle request for a new random word.
loadseed_o  out  1  seed-load strobe to the random stage.
seed_o  out  32  seed to the random stage.
pair_valid_o  out  1  proposal valid.
pair_ready_i  in  1  downstream accepts proposal.
pe_a_o  out  IDX_W  first PE index.
pe_b_o  out  IDX_W  second PE index, always != pe_a_o when valid.
reject_cnt_o  out  CNT_W  total rejected draws since reset or seed load; saturates at all-ones.
busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async): state=IDLE; next_rand_o=0, pair_valid_o=0, pe_a_o=0, pe_b_o=0, reject_cnt_o=0, busy_o=0.
- Random-stage timing contract: next_rand_o high in cycle t makes rand_i valid in cycle t+1. The picker samples rand_i only in WAIT states.
- Candidate index cand = rand_i[IDX_W-1:0]. It is accepted only when cand < N_PE; compare unsigned.
- FSM:
  - IDLE: if enable_i, go to REQ_A.
  - REQ_A: next_rand_o=1; go to WAIT_A.
  - WAIT_A: if cand<N_PE, a_q<=cand and go to REQ_B; else reject_cnt++ and go to REQ_A.
  - REQ_B: next_rand_o=1; go to WAIT_B.
  - WAIT_B: if cand<N_PE and cand!=a_q, b_q<=cand and go to OUT; else reject_cnt++ and go to REQ_B. a_q is kept.
  - OUT: pair_valid_o=1; pe_a_o/pe_b_o hold stable until handshake. On pair_valid_o & pair_ready_i, go to REQ_A if enable_i, else IDLE.
- next_rand_o is registered and high only in REQ_A/REQ_B.
- Minimum latency: enable_i sampled in IDLE at cycle 0 gives pair_valid_o high at cycle 5. Back-to-back proposals complete every 5 cycles when there are no rejects and ready is held high.
- enable_i deasserted mid-draw: the current proposal still completes; enable_i is only checked in IDLE and on OUT exit.
- pair_ready_i outside OUT is ignored.
- Seed load:
  - loadseed_o = seed_load_i and seed_o = seed_i, combinational pass-through.
  - While seed_load_i is high, next_rand_o is forced to 0.
  - On a cycle with seed_load_i high, the FSM goes to IDLE, pair_valid_o clears next cycle, and reject_cnt_o clears.
  - An unconsumed proposal is discarded.
  - seed_load_i has priority over every FSM transition, including an OUT handshake in the same cycle. That handshake does not count as accepted and downstream must not take it.
- Reset mid-operation: immediate return to reset values regardless of state; no partial pair is ever emitted.
- reject_cnt_o saturates at 2^CNT_W-1 and never wraps.
- Illegal parameters (N_PE<2 or 2^IDX_W<N_PE) are excluded by a static elaboration check.

Test Plan:
1. Reset: assert reset asynchronously mid-cycle while in WAIT_B -> all outputs 0 immediately, state IDLE. Release, then enable_i=1 -> next_rand_o high exactly one cycle later.
2. Clean draw, N_PE=12: stub returns 0x00000003 then 0x00000007 -> pair_valid_o at cycle 5, pe_a_o=3, pe_b_o=7, reject_cnt_o=0.
3. Rejection, N_PE=12: stub returns 0x0000000E, 0x00000005, 0x00000005, 0xFFFFFFFB -> pe_a_o=5, pe_b_o=11, reject_cnt_o=2 (out-of-range 14, duplicate 5), next_rand_o pulsed 4 times.
4. Backpressure: pair_ready_i=0 for 10 cycles in OUT -> pair_valid_o stays 1, pe_a_o/pe_b_o stable, no next_rand_o pulses. Ready=1 with enable_i=1 -> next_rand_o pulses the following cycle.
5. Seed load during OUT with pair_ready_i=1: seed_i=0xDEADBEEF -> loadseed_o=1 and seed_o=0xDEADBEEF the same cycle, next_rand_o=0, pair_valid_o=0 next cycle, reject_cnt_o=0, state IDLE.
6. Saturation, CNT_W=4: stub always returns 0x0000000F with N_PE=12 -> reject_cnt_o climbs to 15 and holds. busy_o=1 throughout and pair_valid_o never asserts.
